// File: rtl/relu_pool_stage.sv
`default_nettype none
// relu_pool_stage: ReLU + shift/saturate requant to u8 + 2x2 stride-2 max pool.
// Rev 1.0. Optional SAT_COUNT_EN adds the sat_count port and counter.
module relu_pool_stage #(
  parameter int IMG_W = 10,
  parameter int IMG_H = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  shift,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        done
`ifdef SAT_COUNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PN    = IMG_W / 2;
  localparam int PW    = (PN > 1) ? $clog2(PN) : 1;
  localparam int CKEEP = 2 * (IMG_W / 2);
  localparam int RKEEP = 2 * (IMG_H / 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [4:0]      shift_q;
  logic [7:0]      held;
  logic [7:0]      lbuf [PN];

  logic            fire;
  logic            is_last;
  logic            keep;
  logic            neg;
  logic            sat_hit;
  logic [31:0]     shifted;
  logic [7:0]      q;
  logic [PW-1:0]   p;
  logic [7:0]      lbuf_rd;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign done     = (state == ST_DONE);
  assign fire     = in_valid && in_ready;
  assign is_last  = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign keep     = (int'(col) < CKEEP) && (int'(row) < RKEEP);

  // Negative samples never reach the shifter, so a logical shift suffices.
  assign neg      = in_data[31];
  assign shifted  = in_data >> shift_q;
  assign sat_hit  = !neg && (|shifted[31:8]);
  assign q        = neg ? 8'd0 : (sat_hit ? 8'hFF : shifted[7:0]);

  assign p        = PW'(col >> 1);
  assign lbuf_rd  = lbuf[p];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (fire && is_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!out_valid || out_ready) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      shift_q   <= '0;
      held      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE) begin
        row <= '0;
        col <= '0;
        if (start) shift_q <= shift;
      end else if (fire) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (keep && !col[0]) begin
          held <= row[0] ? max8(lbuf_rd, q) : q;
        end
      end

      // The consumer may drain the register in the same cycle a new result lands.
      if (fire && keep && row[0] && col[0]) begin
        out_valid <= 1'b1;
        out_data  <= max8(held, q);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Line buffer is always written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (fire && keep && !row[0] && col[0]) begin
      lbuf[p] <= max8(held, q);
    end
  end

`ifdef SAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if ((state == ST_IDLE) && start) begin
      sat_count <= '0;
    end else if (fire && sat_hit && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_relu_pool_stage.sv
`default_nettype none
// tb_relu_pool_stage: directed vector table on a 4x4 instance plus corner sequences
// (5x5 floor pooling, output backpressure, mid-frame reset).
module tb_relu_pool_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start5;
  logic [4:0]  shift;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready4, out_valid4, done4;
  logic [7:0]  out_data4;
  logic        in_ready5, out_valid5, done5;
  logic [7:0]  out_data5;
`ifdef SAT_COUNT_EN
  logic [15:0] sat4, sat5;
`endif

  always #5 clk = ~clk;

  relu_pool_stage #(.IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .shift(shift),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .done(done4)
`ifdef SAT_COUNT_EN
    , .sat_count(sat4)
`endif
  );

  relu_pool_stage #(.IMG_W(5), .IMG_H(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .shift(shift),
    .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data),
    .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5),
    .done(done5)
`ifdef SAT_COUNT_EN
    , .sat_count(sat5)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
    end
  endtask

  // Monitor: samples settled values mid-low-phase, i.e. what the next rising edge sees.
  int         cyc = 0;
  logic [7:0] q4[$];
  logic [7:0] q5[$];
  int         done4_n = 0, done5_n = 0;
  int         done4_cyc = 0, done5_cyc = 0;
  int         acc4_cyc = 0, acc5_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    #2;
    if (out_valid4 && out_ready) q4.push_back(out_data4);
    if (out_valid5 && out_ready) q5.push_back(out_data5);
    if (done4) begin done4_n++; done4_cyc = cyc; end
    if (done5) begin done5_n++; done5_cyc = cyc; end
    if (in_valid && in_ready4) acc4_cyc = cyc;
    if (in_valid && in_ready5) acc5_cyc = cyc;
  end

  task automatic start_frame(input bit sel5, input logic [4:0] sh);
    shift = sh;
    if (sel5) start5 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start5 = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input bit sel5, input logic [31:0] x);
    int t;
    in_valid = 1'b1;
    in_data  = x;
    #1;
    t = 0;
    while (!(sel5 ? in_ready5 : in_ready4) && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!(sel5 ? in_ready5 : in_ready4)) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input bit sel5);
    int t;
    in_valid = 1'b0;
    t = 0;
    while (((sel5 ? done5_n : done4_n) == 0) && t < 30) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_out4(input string name, input logic [31:0] exp);
    logic [7:0] got;
    check({name, "_count"}, q4.size(), 4);
    for (int k = 0; k < 4; k++) begin
      got = (k < q4.size()) ? q4[k] : 8'hxx;
      check($sformatf("%s_out%0d", name, k), {24'd0, got}, {24'd0, exp[k*8 +: 8]});
    end
  endtask

  typedef struct packed {
    logic [4:0]  sh;
    logic [31:0] base;
    logic [31:0] step;
    logic [31:0] exp;   // {out3, out2, out1, out0}
    logic [15:0] sat;
  } vec_t;

  vec_t vt [0:8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       v;
    logic [31:0] x;

    // sample i of the 4x4 frame is base + step*i
    vt[0] = '{5'd0,  32'd0,          32'd1,          {8'd15,  8'd13,  8'd7,   8'd5},   16'd0};
    vt[1] = '{5'd0,  32'hFFFF_FFF9,  32'd0,          {8'd0,   8'd0,   8'd0,   8'd0},   16'd0};
    vt[2] = '{5'd4,  32'd8000,       32'd0,          {8'd255, 8'd255, 8'd255, 8'd255}, 16'd16};
    vt[3] = '{5'd1,  32'd0,          32'd1,          {8'd7,   8'd6,   8'd3,   8'd2},   16'd0};
    vt[4] = '{5'd31, 32'h7FFF_FFFF,  32'd0,          {8'd0,   8'd0,   8'd0,   8'd0},   16'd0};
    vt[5] = '{5'd0,  32'd255,        32'd0,          {8'd255, 8'd255, 8'd255, 8'd255}, 16'd0};
    vt[6] = '{5'd0,  32'd256,        32'd0,          {8'd255, 8'd255, 8'd255, 8'd255}, 16'd16};
    vt[7] = '{5'd0,  32'd100,        32'hFFFF_FFF6,  {8'd0,   8'd20,  8'd80,  8'd100}, 16'd0};
    vt[8] = '{5'd8,  32'h0000_FF00,  32'd256,        {8'd255, 8'd255, 8'd255, 8'd255}, 16'd15};

    rst_n = 1'b0; start4 = 1'b0; start5 = 1'b0; shift = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready4}, 0);
    check("rst_out_valid", {31'd0, out_valid4}, 0);
    check("rst_out_data", {24'd0, out_data4}, 0);
    check("rst_done", {31'd0, done4}, 0);
`ifdef SAT_COUNT_EN
    check("rst_sat", {16'd0, sat4}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 9; n++) begin
      v = vt[n];
      q4.delete();
      done4_n = 0;
      start_frame(1'b0, v.sh);
      for (int i = 0; i < 16; i++) begin
        x = v.base + v.step * 32'(i);
        send(1'b0, x);
      end
      wait_done(1'b0);
      check_out4($sformatf("vec%0d", n), v.exp);
      check($sformatf("vec%0d_done_n", n), done4_n, 1);
      check($sformatf("vec%0d_done_lat", n), done4_cyc - acc4_cyc, 2);
`ifdef SAT_COUNT_EN
      check($sformatf("vec%0d_sat", n), {16'd0, sat4}, {16'd0, v.sat});
`endif
    end

    // 5x5: last row/column are consumed but pooled away
    q5.delete();
    done5_n = 0;
    start_frame(1'b1, 5'd0);
    for (int i = 0; i < 25; i++) send(1'b1, 32'(i));
    wait_done(1'b1);
    check("w5_count", q5.size(), 4);
    check("w5_out0", (q5.size() > 0) ? {24'd0, q5[0]} : 32'hxxxx_xxxx, 6);
    check("w5_out1", (q5.size() > 1) ? {24'd0, q5[1]} : 32'hxxxx_xxxx, 8);
    check("w5_out2", (q5.size() > 2) ? {24'd0, q5[2]} : 32'hxxxx_xxxx, 16);
    check("w5_out3", (q5.size() > 3) ? {24'd0, q5[3]} : 32'hxxxx_xxxx, 18);
    check("w5_done_n", done5_n, 1);
    check("w5_done_lat_ok", ((done5_cyc - acc5_cyc) >= 1 && (done5_cyc - acc5_cyc) <= 2) ? 1 : 0, 1);

    // Backpressure: hold out_ready low 10 cycles after the first result; a stray
    // start with a different shift mid-frame must be ignored.
    q4.delete();
    done4_n = 0;
    start_frame(1'b0, 5'd0);
    fork
      begin
        for (int i = 0; i < 16; i++) send(1'b0, 32'(i));
      end
      begin : bp_ctl
        int t;
        t = 0;
        while (!out_valid4 && t < 100) begin
          @(negedge clk);
          t++;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          #2;
          check("bp_out_data", {24'd0, out_data4}, 5);
          check("bp_out_valid", {31'd0, out_valid4}, 1);
          check("bp_in_ready", {31'd0, in_ready4}, 0);
          if (k == 3) begin shift = 5'd7; start4 = 1'b1; end
          if (k == 4) start4 = 1'b0;
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    wait_done(1'b0);
    check_out4("bp", {8'd15, 8'd13, 8'd7, 8'd5});
    check("bp_done_n", done4_n, 1);

    // Mid-frame reset after 6 samples, then a clean frame
    q4.delete();
    done4_n = 0;
    start_frame(1'b0, 5'd0);
    for (int i = 0; i < 6; i++) send(1'b0, 32'(i + 40));
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, in_ready4}, 0);
    check("abort_out_valid", {31'd0, out_valid4}, 0);
    check("abort_out_data", {24'd0, out_data4}, 0);
`ifdef SAT_COUNT_EN
    check("abort_sat", {16'd0, sat4}, 0);
`endif
    repeat (6) @(negedge clk);
    check("abort_no_done", done4_n, 0);
    q4.delete();
    start_frame(1'b0, 5'd0);
    for (int i = 0; i < 16; i++) send(1'b0, 32'(i));
    wait_done(1'b0);
    check_out4("post_rst", {8'd15, 8'd13, 8'd7, 8'd5});
    check("post_rst_done_n", done4_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relu_pool_stage.md
# relu_pool_stage

Downstream stage of the convolution datapath: consumes the 32-bit signed accumulator stream produced by one PE channel in raster order. Applies ReLU, requantizes to 8-bit unsigned by arithmetic right shift with saturation, and performs 2x2 stride-2 max pooling. Emits one pooled 8-bit stream per frame over a valid/ready handshake, ready for write-back to the next layer's memory reader. One instance per PE channel.

## Interface
- IMG_W, 10, input feature-map width in samples; must be ≥2
- IMG_H, 10, input feature-map height in rows; must be ≥2
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse; begins a frame when in IDLE
- shift  input  5  requant right-shift amount; sampled on accepted start, held for the frame
- in_valid  input  1  in_data is valid
- in_ready  output  1  stage accepts in_data this cycle
- in_data  input  32  signed PE accumulator sample, raster order (row-major)
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  8  pooled unsigned value
- done  output  1  one-cycle pulse at frame completion
- sat_count  output  16  saturation counter; port exists only with SAT_COUNT_EN

## Operation
- States:
  - IDLE: start→RUN; clears row/col counters; latches shift.
  - RUN: accepts samples. After the last sample (row IMG_H-1, col IMG_W-1) is accepted→DRAIN.
  - DRAIN: waits for out_valid=0 or the handshake to complete→DONE.
  - DONE: asserts done for one cycle→IDLE.
- start outside IDLE is ignored.
- Sample transfer occurs when in_valid & in_ready. in_ready = (state==RUN) & (!out_valid | out_ready).
- Requant q per sample:
  - x<0 → 0.
  - Otherwise v = x >>> shift; q = (v>255) ? 255 : v[7:0].
- Counters: col 0..IMG_W-1 wraps to 0 and increments row. row 0..IMG_H-1.
- Pooling uses pool-column p=col>>1. Samples with col ≥ 2*(IMG_W/2) or row ≥ 2*(IMG_H/2) are accepted and discarded (floor pooling).
- Line buffer: IMG_W/2 entries × 8 bits.
  - Even row, even col: held = q.
  - Even row, odd col: lbuf[p] = max(held, q).
  - Odd row, even col: held = max(lbuf[p], q).
  - Odd row, odd col: output register ← max(held, q); out_valid=1.
- Output register holds until out_valid & out_ready. A new output may be loaded in the same cycle the previous one is consumed.
- Pooled outputs per frame: (IMG_W/2)*(IMG_H/2), raster order.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, done=0, sat_count=0; state=IDLE; counters, held and shift register =0. Line buffer is not reset (always written before read).
- rst_n low mid-frame: all of the above is restored at the next edge. The partial frame is abandoned and no done is issued.
- start accepted at edge N → in_ready can be high in cycle N+1.
- Latency: pooled output valid the cycle after its 4th contributing sample is accepted.
- Throughput: one sample per cycle while out_ready=1. Backpressure on out_ready stalls in_ready combinationally in the same cycle.
- done asserts the cycle after the final pooled value is accepted, or the cycle after the last sample if the final samples were discarded and the output register is empty.
- Arithmetic: comparisons unsigned 8-bit. Shift 0..31 is legal; shift 31 of any positive value gives 0.

## Configuration
- SAT_COUNT_EN defined:
  - sat_count port present.
  - Increments (saturating at 16'hFFFF) on each accepted sample where v>255.
  - Cleared on reset and on accepted start.
- Undefined: port and counter absent; datapath unchanged.

## Test plan
- IMG_W=IMG_H=4, shift=0, inputs 0..15 raster, out_ready=1 → outputs 5,7,13,15 in order; done one cycle after 15 accepted.
- All inputs -7 → four outputs of 0. With SAT_COUNT_EN, sat_count=0.
- shift=4, input 32'd8000 everywhere → out_data 255 ×4. With SAT_COUNT_EN, sat_count=16.
- IMG_W=IMG_H=5, inputs 0..24 → outputs 6,8,16,18; row 4 / col 4 samples accepted but produce no output; done still asserted.
- out_ready held 0 for 10 cycles after first output → out_data stable at 5, in_ready=0 throughout, no sample lost; stream resumes once released.
- rst_n low for one cycle after 6 samples, then start with inputs 0..15 → clean outputs 5,7,13,15; no done from the aborted frame.
